// File: rtl/traffic_phase_ctrl_pkg.sv
// traffic_pkg: phase encodings, lamp patterns and default durations shared by
// the traffic phase controller and its interface. Revision 1.0.
`default_nettype none

package traffic_pkg;

  typedef enum logic [2:0] {
    ST_AR1  = 3'd0,
    ST_NS_G = 3'd1,
    ST_NS_Y = 3'd2,
    ST_AR2  = 3'd3,
    ST_EW_G = 3'd4,
    ST_EW_Y = 3'd5,
    ST_EMG  = 3'd6,
    ST_NGT  = 3'd7
  } phase_e;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam int DEF_G_NS    = 30;
  localparam int DEF_G_EW    = 20;
  localparam int DEF_Y_TIME  = 3;
  localparam int DEF_AR_TIME = 1;

  // A zero duration would stall the countdown, so it is treated as one second.
  function automatic logic [6:0] dur_sat(input int d);
    if (d < 1) begin
      return 7'd1;
    end else if (d > 99) begin
      return 7'd99;
    end else begin
      return 7'(d);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: seconds strobe, override requests and lamp/display
// outputs of the phase controller. Revision 1.0.
`default_nettype none

interface traffic_phase_ctrl_if;

  logic       sec_clk;
  logic       emerg;
  logic       night;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [6:0] remain;
  logic [2:0] phase;

  modport master (
    output sec_clk, emerg, night,
    input  ns_light, ew_light, remain, phase
  );

  modport slave (
    input  sec_clk, emerg, night,
    output ns_light, ew_light, remain, phase
  );

endinterface

`default_nettype wire

// File: rtl/traffic_phase_ctrl_edge_pulse.sv
// edge_pulse: one-cycle pulse on each rising edge of a same-clock-domain level;
// RST_VAL sets the history bit in reset so a high input there is not an edge. Revision 1.0.
`default_nettype none

module edge_pulse #(
  parameter logic RST_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_sig,
  output logic      o_pulse
);

  logic r_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d <= RST_VAL;
    end else begin
      r_d <= i_sig;
    end
  end

  assign o_pulse = i_sig & ~r_d;

endmodule

`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: six-phase two-road light sequencer with per-phase countdown
// and emergency all-red; night flashing when NIGHT_MODE_EN is defined. Revision 1.0.
`default_nettype none

module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int G_NS    = DEF_G_NS,
  parameter int G_EW    = DEF_G_EW,
  parameter int Y_TIME  = DEF_Y_TIME,
  parameter int AR_TIME = DEF_AR_TIME
) (
  input wire logic             clk,
  input wire logic             rst_n,
  traffic_phase_ctrl_if.slave  bus
);

  localparam logic [6:0] C_G_NS = dur_sat(G_NS);
  localparam logic [6:0] C_G_EW = dur_sat(G_EW);
  localparam logic [6:0] C_Y    = dur_sat(Y_TIME);
  localparam logic [6:0] C_AR   = dur_sat(AR_TIME);

  function automatic phase_e next_phase(input phase_e s);
    case (s)
      ST_AR1:  return ST_NS_G;
      ST_NS_G: return ST_NS_Y;
      ST_NS_Y: return ST_AR2;
      ST_AR2:  return ST_EW_G;
      ST_EW_G: return ST_EW_Y;
      default: return ST_AR1;
    endcase
  endfunction

  function automatic logic [6:0] phase_dur(input phase_e s);
    case (s)
      ST_NS_G:         return C_G_NS;
      ST_EW_G:         return C_G_EW;
      ST_NS_Y, ST_EW_Y: return C_Y;
      default:         return C_AR;
    endcase
  endfunction

  logic       w_tick;
  phase_e     r_state, w_nxt_state, w_adv;
  logic [6:0] r_cnt, w_nxt_cnt;
  logic [2:0] r_ns, r_ew, w_ns, w_ew;
  logic [6:0] r_remain;
  logic [2:0] r_phase;
`ifdef NIGHT_MODE_EN
  logic       r_blink, w_nxt_blink;
`endif

  edge_pulse #(.RST_VAL(1'b1)) u_sec_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sig   (bus.sec_clk),
    .o_pulse (w_tick)
  );

  assign w_adv = next_phase(r_state);

  // Priority is emergency, then night, then the seconds tick.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
`ifdef NIGHT_MODE_EN
    w_nxt_blink = r_blink;
`endif
    if (bus.emerg) begin
      w_nxt_state = ST_EMG;
      w_nxt_cnt   = 7'd0;
    end
`ifdef NIGHT_MODE_EN
    else if (bus.night) begin
      w_nxt_state = ST_NGT;
      w_nxt_cnt   = 7'd0;
      if (r_state != ST_NGT) begin
        w_nxt_blink = 1'b0;
      end else if (w_tick) begin
        w_nxt_blink = ~r_blink;
      end
    end
`endif
    else begin
      case (r_state)
        ST_EMG, ST_NGT: begin
          w_nxt_state = ST_AR1;
          w_nxt_cnt   = C_AR;
        end
        default: begin
          if (w_tick) begin
            if (r_cnt <= 7'd1) begin
              w_nxt_state = w_adv;
              w_nxt_cnt   = phase_dur(w_adv);
            end else begin
              w_nxt_cnt = r_cnt - 7'd1;
            end
          end
        end
      endcase
    end
  end

  // Lamps come from the next state so they move on the same edge as the phase.
  always_comb begin
    w_ns = LAMP_R;
    w_ew = LAMP_R;
    case (w_nxt_state)
      ST_NS_G: w_ns = LAMP_G;
      ST_NS_Y: w_ns = LAMP_Y;
      ST_EW_G: w_ew = LAMP_G;
      ST_EW_Y: w_ew = LAMP_Y;
      ST_NGT: begin
`ifdef NIGHT_MODE_EN
        w_ns = w_nxt_blink ? LAMP_Y : LAMP_OFF;
        w_ew = w_nxt_blink ? LAMP_Y : LAMP_OFF;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_AR1;
      r_cnt    <= C_AR;
      r_ns     <= LAMP_R;
      r_ew     <= LAMP_R;
      r_remain <= C_AR;
      r_phase  <= ST_AR1;
`ifdef NIGHT_MODE_EN
      r_blink  <= 1'b0;
`endif
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_ns     <= w_ns;
      r_ew     <= w_ew;
      r_remain <= w_nxt_cnt;
      r_phase  <= w_nxt_state;
`ifdef NIGHT_MODE_EN
      r_blink  <= w_nxt_blink;
`endif
    end
  end

  assign bus.ns_light = r_ns;
  assign bus.ew_light = r_ew;
  assign bus.remain   = r_remain;
  assign bus.phase    = r_phase;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed and randomized checks of the phase controller
// against a phase-table reference model.
`default_nettype none

module tb_traffic_phase_ctrl;

  localparam int G_NS = 3;
  localparam int G_EW = 2;
  localparam int Y_T  = 1;
  localparam int AR_T = 1;
`ifdef NIGHT_MODE_EN
  localparam bit NIGHT_EN = 1'b1;
`else
  localparam bit NIGHT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  traffic_phase_ctrl_if u_if();

  traffic_phase_ctrl #(.G_NS(G_NS), .G_EW(G_EW), .Y_TIME(Y_T), .AR_TIME(AR_T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sec_ph  = 0;
  bit tb_emerg = 1'b0;
  bit tb_night = 1'b0;
  bit last_tick;

  // Reference: phase table indexed 0..5, mode 0=normal 1=emergency 2=night.
  int         dur[6]    = '{AR_T, G_NS, Y_T, AR_T, G_EW, Y_T};
  logic [2:0] ns_tab[6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
  int m_mode = 0, m_idx = 0, m_rem = AR_T;
  bit m_sec_d = 1'b1, m_blink = 1'b0;
  logic [2:0] e_phase, e_ns, e_ew;
  logic [6:0] e_rem;

  task automatic step();
    bit sec, tick;
    sec = (sec_ph >= 4);
    u_if.sec_clk = sec;
    u_if.emerg   = tb_emerg;
    u_if.night   = tb_night;
    tick = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_idx = 0; m_rem = AR_T; m_sec_d = 1'b1; m_blink = 1'b0;
    end else begin
      tick = sec && !m_sec_d;
      m_sec_d = sec;
      if (tb_emerg) m_mode = 1;
      else if (NIGHT_EN && tb_night) begin
        if (m_mode != 2) begin m_mode = 2; m_blink = 1'b0; end
        else if (tick) m_blink = !m_blink;
      end else if (m_mode != 0) begin
        m_mode = 0; m_idx = 0; m_rem = dur[0];
      end else if (tick) begin
        if (m_rem <= 1) begin m_idx = (m_idx + 1) % 6; m_rem = dur[m_idx]; end
        else m_rem = m_rem - 1;
      end
    end
    last_tick = tick;
    if (m_mode == 1) begin
      e_phase = 3'd6; e_rem = 7'd0; e_ns = 3'b100; e_ew = 3'b100;
    end else if (m_mode == 2) begin
      e_phase = 3'd7; e_rem = 7'd0;
      e_ns = m_blink ? 3'b010 : 3'b000; e_ew = e_ns;
    end else begin
      e_phase = 3'(m_idx); e_rem = 7'(m_rem); e_ns = ns_tab[m_idx]; e_ew = ew_tab[m_idx];
    end
    @(posedge clk);
    @(negedge clk);
    sec_ph = (sec_ph + 1) % 8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sec_ph = 4;
      step();
    end
    n_tests++;
    if ({u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light} !== {3'd0, 7'd1, 3'b100, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_state: phase=%0d remain=%0d ns=%b ew=%b, want 0 1 100 100",
               u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light);
    end
    rst_n = 1'b1;
    sec_ph = 4;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({u_if.phase, u_if.remain} !== {3'd0, 7'd1}) begin
        n_fail++;
        $display("FAIL reset_no_tick cyc%0d: phase=%0d remain=%0d, want 0 1", i, u_if.phase, u_if.remain);
      end
    end
  endtask

  task automatic test_full_cycle();
    int exp_ph[9]  = '{1, 1, 1, 2, 3, 4, 4, 5, 0};
    int exp_rem[9] = '{3, 2, 1, 1, 1, 2, 1, 1, 1};
    int k = 0;
    int guard = 0;
    while (k < 9 && guard < 120) begin
      step();
      guard++;
      n_tests++;
      if ({u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light} !== {e_phase, e_rem, e_ns, e_ew}) begin
        n_fail++;
        $display("FAIL cycle_model: phase=%0d remain=%0d ns=%b ew=%b, want %0d %0d %b %b",
                 u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light, e_phase, e_rem, e_ns, e_ew);
      end
      if (last_tick) begin
        n_tests++;
        if ({u_if.phase, u_if.remain} !== {3'(exp_ph[k]), 7'(exp_rem[k])}) begin
          n_fail++;
          $display("FAIL cycle_tick%0d: phase=%0d remain=%0d, want %0d %0d",
                   k, u_if.phase, u_if.remain, exp_ph[k], exp_rem[k]);
        end
        k++;
      end
    end
    if (k < 9) begin
      n_tests++; n_fail++;
      $display("FAIL cycle_timeout: ticks seen %0d, want 9", k);
    end
  endtask

  task automatic test_emerg_mid();
    int guard = 0;
    while (!(u_if.phase == 3'd1 && u_if.remain == 7'd2) && guard < 200) begin step(); guard++; end
    n_tests++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL emerg_wait: phase=%0d remain=%0d, want 1 2", u_if.phase, u_if.remain);
    end
    tb_emerg = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++;
      if ({u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light} !== {3'd6, 7'd0, 3'b100, 3'b100}) begin
        n_fail++;
        $display("FAIL emerg_hold cyc%0d: phase=%0d remain=%0d ns=%b ew=%b, want 6 0 100 100",
                 i, u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light);
      end
    end
    tb_emerg = 1'b0;
    step();
    n_tests++;
    if ({u_if.phase, u_if.remain, u_if.ns_light} !== {3'd0, 7'd1, 3'b100}) begin
      n_fail++;
      $display("FAIL emerg_release: phase=%0d remain=%0d ns=%b, want 0 1 100", u_if.phase, u_if.remain, u_if.ns_light);
    end
    guard = 0;
    do begin step(); guard++; end while (!last_tick && guard < 20);
    n_tests++;
    if ({u_if.phase, u_if.remain} !== {3'd1, 7'd3}) begin
      n_fail++;
      $display("FAIL emerg_next_tick: phase=%0d remain=%0d, want 1 3", u_if.phase, u_if.remain);
    end
  endtask

  task automatic test_emerg_collision();
    int guard = 0;
    while (!(u_if.phase == 3'd5 && sec_ph == 4) && guard < 200) begin step(); guard++; end
    n_tests++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL collide_wait: phase=%0d, want 5 before tick", u_if.phase);
    end
    tb_emerg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (u_if.phase !== 3'd6) begin
        n_fail++;
        $display("FAIL collide_emg cyc%0d: phase=%0d, want 6", i, u_if.phase);
      end
    end
    tb_emerg = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!(u_if.phase == 3'd4 && u_if.remain == 7'd2) && guard < 200) begin step(); guard++; end
    n_tests++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL rstmid_wait: phase=%0d remain=%0d, want 4 2", u_if.phase, u_if.remain);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++;
    if ({u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light} !== {3'd0, 7'd1, 3'b100, 3'b100}) begin
      n_fail++;
      $display("FAIL rstmid: phase=%0d remain=%0d ns=%b ew=%b, want 0 1 100 100",
               u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light);
    end
  endtask

  task automatic test_night();
    int k = 0;
    int guard = 0;
    tb_night = 1'b1;
    step();
`ifdef NIGHT_MODE_EN
    n_tests++;
    if ({u_if.phase, u_if.ns_light, u_if.ew_light, u_if.remain} !== {3'd7, 3'b000, 3'b000, 7'd0}) begin
      n_fail++;
      $display("FAIL night_entry: phase=%0d ns=%b ew=%b remain=%0d, want 7 000 000 0",
               u_if.phase, u_if.ns_light, u_if.ew_light, u_if.remain);
    end
`endif
    while (k < 4 && guard < 60) begin
      step();
      guard++;
      n_tests++;
      if ({u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light} !== {e_phase, e_rem, e_ns, e_ew}) begin
        n_fail++;
        $display("FAIL night_model: phase=%0d remain=%0d ns=%b ew=%b, want %0d %0d %b %b",
                 u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light, e_phase, e_rem, e_ns, e_ew);
      end
`ifdef NIGHT_MODE_EN
      if (last_tick) begin
        n_tests++;
        if ({u_if.ns_light, u_if.ew_light} !== ((k % 2 == 0) ? 6'b010_010 : 6'b000_000)) begin
          n_fail++;
          $display("FAIL night_blink%0d: ns=%b ew=%b, want %s", k, u_if.ns_light, u_if.ew_light,
                   (k % 2 == 0) ? "010" : "000");
        end
      end
`endif
      if (last_tick) k++;
    end
    tb_night = 1'b0;
    step();
`ifdef NIGHT_MODE_EN
    n_tests++;
    if ({u_if.phase, u_if.remain} !== {3'd0, 7'd1}) begin
      n_fail++;
      $display("FAIL night_release: phase=%0d remain=%0d, want 0 1", u_if.phase, u_if.remain);
    end
`else
    n_tests++;
    if ({u_if.phase, u_if.remain} !== {e_phase, e_rem}) begin
      n_fail++;
      $display("FAIL night_ignored: phase=%0d remain=%0d, want %0d %0d", u_if.phase, u_if.remain, e_phase, e_rem);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) tb_emerg = !tb_emerg;
      if ($urandom_range(0, 30) == 0) tb_night = !tb_night;
      rst_n = ($urandom_range(0, 150) != 0);
      step();
      n_tests++;
      if ({u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light} !== {e_phase, e_rem, e_ns, e_ew}) begin
        n_fail++;
        $display("FAIL random cyc%0d: phase=%0d remain=%0d ns=%b ew=%b, want %0d %0d %b %b",
                 i, u_if.phase, u_if.remain, u_if.ns_light, u_if.ew_light, e_phase, e_rem, e_ns, e_ew);
      end
    end
    rst_n = 1'b1;
    tb_emerg = 1'b0;
    tb_night = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_emerg_mid();
    test_emerg_collision();
    test_reset_mid();
    test_night();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Phase sequencer for the two-road intersection. Consumes the 1 Hz square wave from the clock divider, converts its rising edge into a one-cycle tick, and steps a six-phase light cycle with per-phase countdown. Drives the north-south and east-west lamp outputs, and the remaining-seconds value the display path renders. Emergency all-red override is built in; night flashing mode is optional.

## Interface
- `G_NS`, default 30: north-south green duration, seconds.
- `G_EW`, default 20: east-west green duration, seconds.
- `Y_TIME`, default 3: yellow duration, seconds, both roads.
- `AR_TIME`, default 1: all-red clearance duration, seconds.
- Legal range for all durations is 1..99. A value of 0 behaves as 1.
- `CLK` input 1: system clock. All logic runs on its rising edge.
- `RST_N` input 1: reset, synchronous, active-low.
- `SEC_CLK` input 1: 1 Hz square wave from the divider, generated in the `CLK` domain.
- `EMERG` input 1: emergency override, level-sensitive.
- `NIGHT` input 1: night mode request, level-sensitive. Always present; ignored unless `NIGHT_MODE_EN` is defined.
- `NS_LIGHT` output 3: north-south lamps, {R,Y,G}, one-hot or 000.
- `EW_LIGHT` output 3: east-west lamps, {R,Y,G}.
- `REMAIN` output 7: seconds left in the current phase, binary 0..99.
- `PHASE` output 3: current state encoding, for display and debug.

## Operation
- Tick generation: `tick = SEC_CLK & ~sec_d`, where `sec_d` is `SEC_CLK` registered. Exactly one tick per `SEC_CLK` rising edge.
- States and lamps:
  - AR1: NS=R, EW=R.
  - NS_G: NS=G, EW=R.
  - NS_Y: NS=Y, EW=R.
  - AR2: NS=R, EW=R.
  - EW_G: NS=R, EW=G.
  - EW_Y: NS=R, EW=Y.
  - EMG: NS=R, EW=R.
  - NGT: NS=Y, EW=Y, blinking.
- Normal cycle: AR1→NS_G→NS_Y→AR2→EW_G→EW_Y→AR1.
- Phase durations, loaded into the 7-bit down-counter `cnt` on entry:
  - AR1 and AR2: `AR_TIME`.
  - NS_G: `G_NS`.
  - NS_Y and EW_Y: `Y_TIME`.
  - EW_G: `G_EW`.
- On each tick in a normal phase:
  - If `cnt <= 1`, advance to the next phase and load its duration.
  - Otherwise, `cnt <= cnt - 1`.
  - `REMAIN = cnt`, so NS_G with `G_NS=30` displays 30,29,…,1.
- `cnt` never wraps below 1 in normal phases.
- Emergency: `EMERG` high on any clock moves the block to EMG on the next edge, from any state. In EMG:
  - `cnt` and `REMAIN` are 0.
  - Ticks are ignored.
- Leaving EMG: the first clock with `EMERG` low enters AR1 with `cnt=AR_TIME`.
- Priority: `EMERG` > `NIGHT` > tick.
  - `EMERG` asserted in the same cycle as an advancing tick goes to EMG; the advance is discarded.
- Lamps, `REMAIN` and `PHASE` are registered. They are decoded from the next-state and next-count values so all outputs change on the same edge as the state.
- Reset (`RST_N` low at a clock edge), including mid-phase or in EMG/NGT:
  - State = AR1, `cnt=AR_TIME`.
  - `NS_LIGHT=EW_LIGHT=100` (red), `REMAIN=AR_TIME`, `PHASE=AR1`.
  - `sec_d=1`, blink=0.
  - `EMERG` and `NIGHT` are ignored while in reset.

## Timing
- Latency from the first `CLK` edge sampling `SEC_CLK` high to the state, count and output update: exactly 1 `CLK` cycle.
- Latency from `EMERG` rising to all-red outputs: 1 `CLK` cycle.
- If `SEC_CLK` is already high when reset is released, no tick is generated. The first tick follows the next full low→high transition.
- A phase lasts exactly N ticks. The first tick after entry shows N-1 remaining.
- Ticks closer than 2 `CLK` cycles cannot occur, because `SEC_CLK` is a divided square wave. No back-to-back handling is required.

## Configuration
- Macro: `NIGHT_MODE_EN`.
- Defined:
  - `NIGHT` high (with `EMERG` low) enters NGT on the next edge.
  - In NGT, a blink register toggles on each tick. Lamps are Y when blink=1 and 000 when blink=0; blink is 0 on entry.
  - `REMAIN` is 0 in NGT.
  - `NIGHT` falling enters AR1 with `cnt=AR_TIME`.
- Undefined:
  - `NIGHT` is ignored and no blink register exists.
  - NGT is unreachable and its encoding is reserved. Any illegal state recovers to AR1 on the next edge.

## Structure
- Shared package `traffic_pkg`:
  - State encodings for `PHASE`, 3 bits, AR1=0 … EW_Y=5, EMG=6, NGT=7.
  - Lamp constants `LAMP_R=3'b100`, `LAMP_Y=3'b010`, `LAMP_G=3'b001`, `LAMP_OFF=3'b000`.
  - Default durations.
- Sub-module `edge_pulse`: the `SEC_CLK` rising-edge detector, with a reset value parameter, instantiated with reset value 1.

## Test plan
All tests use parameters `G_NS=3`, `G_EW=2`, `Y_TIME=1`, `AR_TIME=1`, with `SEC_CLK` period 8 `CLK` cycles.
- Reset release: outputs are NS=100, EW=100, `REMAIN=1`, `PHASE=0`. `SEC_CLK` high at release produces no tick for 4 cycles.
- Full cycle over 9 ticks: `PHASE` reads 1,1,1,2,3,4,4,5,0, and `REMAIN` reads 3,2,1,1,1,2,1,1,1. Each change occurs 1 cycle after a `SEC_CLK` rise.
- `EMERG` pulsed high for 20 cycles mid NS_G: all-red with `REMAIN=0` 1 cycle later, ticks ignored. Release gives AR1 with `REMAIN=1`, then NS_G=3 on the next tick.
- `EMERG` rising in the same cycle as the EW_Y→AR1 tick: `PHASE=6` next cycle, never 0 in between.
- `RST_N` low for 1 cycle during EW_G with `REMAIN=2`: next cycle `PHASE=0`, `REMAIN=1`, lamps all red.
- With `NIGHT_MODE_EN` defined, `NIGHT` held for 4 ticks: lamps read 000 on entry, then 010, 000, 010, 000 on successive ticks. Release gives AR1. Without the macro, the same stimulus produces the normal cycle unchanged.
